// File: rtl/track_phase_decoder.sv
// Receive-side monitor for a 4-wire two-phase stepper coil bus.
// Filters the coil pattern, decodes transitions into signed steps and
// tracks position, direction, step period, motion and drive faults.
module track_phase_decoder #(
    parameter int unsigned POS_W         = 16,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CLK_KHZ       = 50000,
    parameter int unsigned TIMEOUT_MS    = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       phase_i,
    input  logic             home_i,
    input  logic             err_clr_i,
    output logic [POS_W-1:0] pos_o,
    output logic             dir_o,
    output logic             step_o,
    output logic             moving_o,
    output logic [31:0]      period_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    localparam int unsigned      CNT_W       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(STABLE_CYCLES);
    localparam logic [31:0]      TIMEOUT_CYC = 32'(CLK_KHZ * TIMEOUT_MS);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    function automatic logic is_legal(input logic [3:0] p);
        case (p)
            4'b0011, 4'b0110, 4'b1100, 4'b1001: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // Forward order P1->P2->P3->P4->P1 is a left rotation of the coil pattern.
    function automatic logic [3:0] fwd_of(input logic [3:0] p);
        fwd_of = {p[2:0], p[3]};
    endfunction

    function automatic logic [3:0] rev_of(input logic [3:0] p);
        rev_of = {p[0], p[3:1]};
    endfunction

    logic [3:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] stab_q;
    logic [3:0]       filt_q, old_q;
    logic             chg_q;
    state_e           state_q, state_d;

    logic             step_c, fwd_c, idle_c;
    logic [1:0]       err_new_c;
    logic [1:0]       err_code_d;

    logic [POS_W-1:0] pos_q;
    logic             dir_q, step_q, moving_q, armed_q, err_q;
    logic [31:0]      period_q, per_cnt_q;
    logic [1:0]       err_code_q;

    // Synchronize the coil pattern and accept it once it has settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
            stab_q  <= '0;
            filt_q  <= 4'b0000;
            old_q   <= 4'b0000;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= phase_i;
            sync2_q <= sync1_q;
            if (sync1_q != sync2_q) begin
                stab_q <= '0;
            end else if (stab_q != CNT_MAX) begin
                stab_q <= stab_q + CNT_W'(1);
            end
            chg_q <= 1'b0;
            if (stab_q == CNT_MAX && sync2_q != filt_q) begin
                filt_q <= sync2_q;
                old_q  <= filt_q;
                chg_q  <= 1'b1;
            end
        end
    end

    // Decoder state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Decoder next state: any zero or illegal pattern parks it in IDLE.
    always_comb begin
        state_d = state_q;
        if (chg_q) begin
            if (filt_q == 4'b0000 || !is_legal(filt_q)) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_TRACK;
            end
        end
    end

    // Decoder outputs for the pattern change seen this cycle.
    always_comb begin
        step_c    = 1'b0;
        fwd_c     = 1'b0;
        idle_c    = 1'b0;
        err_new_c = 2'b00;
        if (chg_q) begin
            if (filt_q == 4'b0000) begin
                idle_c = 1'b1;
            end else if (!is_legal(filt_q)) begin
                err_new_c[0] = 1'b1;
                idle_c       = 1'b1;
            end else if (state_q == ST_TRACK) begin
                if (filt_q == fwd_of(old_q)) begin
                    step_c = 1'b1;
                    fwd_c  = 1'b1;
                end else if (filt_q == rev_of(old_q)) begin
                    step_c = 1'b1;
                end else begin
                    err_new_c[1] = 1'b1;
                end
            end
        end
    end

    assign err_code_d = (err_clr_i ? 2'b00 : err_code_q) | err_new_c;

    // Position, period, motion and fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q      <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            moving_q   <= 1'b0;
            armed_q    <= 1'b0;
            period_q   <= '0;
            per_cnt_q  <= '0;
            err_code_q <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            step_q <= step_c;
            if (step_c) begin
                dir_q <= fwd_c;
            end
            if (home_i) begin
                pos_q <= '0;
            end else if (step_c) begin
                pos_q <= fwd_c ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            end
            if (step_c) begin
                period_q  <= armed_q ? per_cnt_q : 32'hFFFF_FFFF;
                per_cnt_q <= 32'd1;
                armed_q   <= 1'b1;
            end else begin
                if (per_cnt_q != 32'hFFFF_FFFF) begin
                    per_cnt_q <= per_cnt_q + 32'd1;
                end
                if (idle_c) begin
                    armed_q <= 1'b0;
                end
            end
            if (step_c) begin
                moving_q <= 1'b1;
            end else if (idle_c || per_cnt_q >= TIMEOUT_CYC) begin
                moving_q <= 1'b0;
            end
            err_code_q <= err_code_d;
            err_q      <= |err_code_d;
        end
    end

    assign pos_o      = pos_q;
    assign dir_o      = dir_q;
    assign step_o     = step_q;
    assign moving_o   = moving_q;
    assign period_o   = period_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_track_phase_decoder.sv
// Testbench for track_phase_decoder: directed coil sequences checked against
// a pattern-history model every cycle plus hand-computed expectations.
module tb_track_phase_decoder;

    localparam int S     = 4;
    localparam int KHZ   = 50;
    localparam int TMS   = 1;
    localparam int LIMIT = KHZ * TMS;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  phase_i = 4'b0000;
    logic        home_i = 1'b0;
    logic        err_clr_i = 1'b0;

    logic [15:0] pos_o;
    logic        dir_o, step_o, moving_o, err_o;
    logic [31:0] period_o;
    logic [1:0]  err_code_o;

    logic [3:0]  pos4_o;
    logic        dir4_o, step4_o, moving4_o, err4_o;
    logic [31:0] period4_o;
    logic [1:0]  err_code4_o;

    always #5 clk = ~clk;

    track_phase_decoder #(.POS_W(16), .STABLE_CYCLES(S), .CLK_KHZ(KHZ), .TIMEOUT_MS(TMS)) dut (
        .clk(clk), .rst(rst), .phase_i(phase_i), .home_i(home_i), .err_clr_i(err_clr_i),
        .pos_o(pos_o), .dir_o(dir_o), .step_o(step_o), .moving_o(moving_o),
        .period_o(period_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    // Narrow position counter so signed wrap is reachable in a short run.
    track_phase_decoder #(.POS_W(4), .STABLE_CYCLES(S), .CLK_KHZ(KHZ), .TIMEOUT_MS(TMS)) dut4 (
        .clk(clk), .rst(rst), .phase_i(phase_i), .home_i(home_i), .err_clr_i(err_clr_i),
        .pos_o(pos4_o), .dir_o(dir4_o), .step_o(step4_o), .moving_o(moving4_o),
        .period_o(period4_o), .err_o(err4_o), .err_code_o(err_code4_o)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stepcnt = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (chk_en && step_o === 1'b1) stepcnt = stepcnt + 1;
    end

    // ---------------- behavioural model ----------------
    logic [3:0]  hist [0:7];
    logic [3:0]  m_filt = 4'b0, m_old = 4'b0;
    logic        m_ev = 1'b0, m_track = 1'b0;
    logic [15:0] m_pos = 16'd0;
    logic [3:0]  m_pos4 = 4'd0;
    logic        m_dir = 1'b0, m_step = 1'b0, m_moving = 1'b0, m_armed = 1'b0, m_err = 1'b0;
    logic [31:0] m_period = 32'd0, m_cnt = 32'd0;
    logic [1:0]  m_code = 2'b00;

    // Position of a legal pattern in the forward cycle, -1 otherwise.
    function automatic int idx(input logic [3:0] p);
        case (p)
            4'b0011: return 0;
            4'b0110: return 1;
            4'b1100: return 2;
            4'b1001: return 3;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic       stp, fwd, idl, same;
        logic [1:0] ne;
        int         d;
        if (rst) begin
            for (int i = 0; i < 8; i++) hist[i] = 4'b0000;
            m_filt = 4'b0; m_old = 4'b0; m_ev = 1'b0; m_track = 1'b0;
            m_pos = 16'd0; m_pos4 = 4'd0; m_dir = 1'b0; m_step = 1'b0;
            m_moving = 1'b0; m_armed = 1'b0; m_period = 32'd0; m_cnt = 32'd0;
            m_code = 2'b00; m_err = 1'b0;
        end else begin
            stp = 1'b0; fwd = 1'b0; idl = 1'b0; ne = 2'b00;
            if (m_ev) begin
                if (m_filt == 4'b0000) begin
                    idl = 1'b1; m_track = 1'b0;
                end else if (idx(m_filt) < 0) begin
                    ne[0] = 1'b1; idl = 1'b1; m_track = 1'b0;
                end else if (!m_track) begin
                    m_track = 1'b1;
                end else begin
                    d = (idx(m_filt) - idx(m_old) + 4) % 4;
                    if (d == 1) begin stp = 1'b1; fwd = 1'b1; end
                    else if (d == 3) stp = 1'b1;
                    else ne[1] = 1'b1;
                end
            end
            m_step = stp;
            if (stp) m_dir = fwd;
            if (home_i) begin
                m_pos = 16'd0; m_pos4 = 4'd0;
            end else if (stp) begin
                m_pos  = fwd ? m_pos + 16'd1 : m_pos - 16'd1;
                m_pos4 = fwd ? m_pos4 + 4'd1 : m_pos4 - 4'd1;
            end
            if (stp) m_moving = 1'b1;
            else if (idl || m_cnt >= 32'(LIMIT)) m_moving = 1'b0;
            if (stp) begin
                m_period = m_armed ? m_cnt : 32'hFFFF_FFFF;
                m_cnt = 32'd1;
                m_armed = 1'b1;
            end else begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                if (idl) m_armed = 1'b0;
            end
            m_code = (err_clr_i ? 2'b00 : m_code) | ne;
            m_err = |m_code;
            // A pattern seen on S+1 consecutive samples, two samples back,
            // becomes the new filtered pattern and is decoded next cycle.
            m_ev = 1'b0;
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = phase_i;
            same = 1'b1;
            for (int i = 3; i <= 2 + S; i++) if (hist[i] != hist[2]) same = 1'b0;
            if (same && hist[2] != m_filt) begin
                m_old = m_filt; m_filt = hist[2]; m_ev = 1'b1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [57:0] act, exp;
        if (chk_en) begin
            act = {pos_o, pos4_o, dir_o, step_o, moving_o, period_o, err_o, err_code_o};
            exp = {m_pos, m_pos4, m_dir, m_step, m_moving, m_period, m_err, m_code};
            tests = tests + 1;
            if (act !== exp) begin
                fails = fails + 1;
                $display("FAIL model cyc=%0d got %h expected %h", cyc, act, exp);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] p, input int n);
        phase_i = p;
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int t0, first, s0, ts, tf;
        logic [3:0] fwd_seq [0:7];
        fwd_seq[0] = 4'b0110; fwd_seq[1] = 4'b1100; fwd_seq[2] = 4'b1001; fwd_seq[3] = 4'b0011;
        fwd_seq[4] = 4'b0110; fwd_seq[5] = 4'b1100; fwd_seq[6] = 4'b1001; fwd_seq[7] = 4'b0011;

        // Reset state
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {pos_o, dir_o, step_o, moving_o, period_o, err_o, err_code_o}, 64'd0);
        rst = 1'b0;

        // 1: forward sequence, 20 cycles per pattern
        s0 = stepcnt;
        hold(4'b0000, 20);
        hold(4'b0011, 20);
        phase_i = 4'b0110;
        t0 = cyc;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step_o === 1'b1 && first < 0) first = cyc;
        end
        check("first_step_latency", 64'(first - t0), 64'(1 + S + 3));
        check("first_period", period_o, 32'hFFFF_FFFF);
        hold(4'b1100, 20);
        hold(4'b1001, 20);
        check("period_after_3rd", period_o, 32'd20);
        hold(4'b0011, 20);
        check("fwd_step_count", 64'(stepcnt - s0), 64'd4);
        check("fwd_pos", pos_o, 16'd4);
        check("fwd_dir", dir_o, 1'b1);

        // 2: reverse
        hold(4'b1001, 20);
        hold(4'b1100, 20);
        check("rev_pos", pos_o, 16'd2);
        check("rev_dir", dir_o, 1'b0);
        check("rev_err", err_o, 1'b0);

        // 3: glitch, skipped phase, illegal pattern, clear
        hold(4'b1001, 20);
        hold(4'b0011, 20);
        s0 = stepcnt;
        hold(4'b0110, 2);
        hold(4'b0011, 20);
        check("glitch_no_step", 64'(stepcnt - s0), 64'd0);
        check("glitch_pos", pos_o, 16'd4);
        hold(4'b1100, 20);
        check("skip_code", err_code_o, 2'b10);
        check("skip_no_step", 64'(stepcnt - s0), 64'd0);
        hold(4'b0111, 20);
        check("illegal_code", err_code_o, 2'b11);
        check("illegal_err", err_o, 1'b1);
        check("illegal_idle_moving", moving_o, 1'b0);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        @(negedge clk);
        check("err_clear", {err_o, err_code_o}, 3'b000);

        // 4: signed wrap on the 4-bit instance, then home against a step
        hold(4'b0011, 10);
        home_i = 1'b1;
        @(negedge clk);
        home_i = 1'b0;
        for (int i = 0; i < 7; i++) hold(fwd_seq[i], 10);
        check("pre_wrap_pos4", pos4_o, 4'h7);
        hold(fwd_seq[7], 10);
        check("wrap_pos4", pos4_o, 4'h8);
        check("wrap_pos16", pos_o, 16'd8);
        phase_i = 4'b0110;
        repeat (7) @(negedge clk);
        home_i = 1'b1;
        @(negedge clk);
        home_i = 1'b0;
        check("home_vs_step_step", step_o, 1'b1);
        check("home_vs_step_pos", pos_o, 16'd0);
        hold(4'b0110, 10);

        // 5: motion timeout and IDLE entry
        phase_i = 4'b1100;
        ts = -1;
        tf = -1;
        for (int i = 0; i < 120 && tf < 0; i++) begin
            @(negedge clk);
            if (step_o === 1'b1) ts = cyc;
            else if (ts >= 0 && moving_o === 1'b0) tf = cyc;
        end
        check("moving_timeout", 64'(tf - ts), 64'(LIMIT));
        hold(4'b1001, 10);
        check("moving_after_step", moving_o, 1'b1);
        phase_i = 4'b0000;
        repeat (7) @(negedge clk);
        check("moving_before_idle", moving_o, 1'b1);
        @(negedge clk);
        check("moving_idle_drop", moving_o, 1'b0);
        hold(4'b0000, 10);

        // 6: reset mid-sequence
        hold(4'b0011, 20);
        hold(4'b0110, 20);
        phase_i = 4'b1100;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_outputs", {pos_o, dir_o, step_o, moving_o, period_o, err_o, err_code_o}, 64'd0);
        s0 = stepcnt;
        hold(4'b1100, 20);
        check("anchor_no_step", 64'(stepcnt - s0), 64'd0);
        check("anchor_pos", pos_o, 16'd0);
        hold(4'b1001, 20);
        check("post_reset_pos", pos_o, 16'd1);
        check("post_reset_period", period_o, 32'hFFFF_FFFF);
        check("post_reset_dir", dir_o, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
